// File: rtl/mctrl_loop_seq_pkg.sv
// Shared definitions for the loop sequencer: loop bounds, pointer widths and
// the controller state encoding.
package mctrl_loop_seq_pkg;

    localparam int MRowLoop  = 4;
    localparam int MAColLoop = 4;
    localparam int MWColLoop = 4;

    localparam int RowW  = $clog2(MRowLoop);
    localparam int AColW = $clog2(MAColLoop);
    localparam int WColW = $clog2(MWColLoop);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mctrl_state_e;

endpackage

// File: rtl/mctrl_wrap_cnt.sv
// Wrapping counter: counts 0..last, returns to 0 after last. The wrap output
// is asserted in the enabled cycle that takes the count from last back to 0,
// so it can directly enable the next counter in a nested loop chain.
module mctrl_wrap_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == last);

    // Count register: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mctrl_loop_seq.sv
// Loop sequencer for the MAC array: walks row (inner), weight column
// (middle) and activation column (outer) pointers, one pointer set per
// accepted step, then waits for the array pipeline to drain and pulses done.
//
// Handshake: stepValid/stepReady follow valid/ready rules. A step is
// transferred on a rising edge where both are high; while stepValid is high
// and stepReady is low, the pointer set and accFirst/accLast stay constant.
// stepValid never depends on stepReady.
//
// Every output is decoded from registers only (state, counters, latched
// config), so no input reaches an output combinationally.
module mctrl_loop_seq
    import mctrl_loop_seq_pkg::*;
#(
    parameter int DrainCyc = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [RowW-1:0]  cfgRowLast,
    input  logic [AColW-1:0] cfgAColLast,
    input  logic [WColW-1:0] cfgWColLast,
    output logic             busy,
    output logic             done,
    output logic             stepValid,
    input  logic             stepReady,
    output logic [RowW-1:0]  rowAPtr,
    output logic [RowW-1:0]  rowWPtr,
    output logic [AColW-1:0] colAPtr,
    output logic [WColW-1:0] colWPtr,
    output logic             accFirst,
    output logic             accLast,
    output logic [1:0]       dbgState
);

    // DRAIN always lasts at least one cycle, even with DrainCyc = 0.
    localparam logic [3:0] DrainEnd = (DrainCyc == 0) ? 4'd0 : 4'(DrainCyc - 1);

    mctrl_state_e state;
    mctrl_state_e state_nxt;

    logic [RowW-1:0]  row_last_q;
    logic [AColW-1:0] acol_last_q;
    logic [WColW-1:0] wcol_last_q;
    logic [3:0]       drain_cnt;

    logic [RowW-1:0]  row_cnt;
    logic [AColW-1:0] acol_cnt;
    logic [WColW-1:0] wcol_cnt;

    logic launch;
    logic accept;
    logic all_last;
    logic row_en;
    logic row_wrap;
    logic wcol_wrap;
    logic acol_wrap;

    assign launch   = (state == ST_IDLE) && start;
    assign accept   = (state == ST_RUN) && stepReady;
    assign all_last = (row_cnt == row_last_q) && (wcol_cnt == wcol_last_q)
                      && (acol_cnt == acol_last_q);
    // The final step does not advance the counters so the pointers keep
    // their last values through DRAIN; an abort freezes them as well.
    assign row_en   = accept && !abort && !all_last;

    mctrl_wrap_cnt #(.W(RowW)) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (row_en),
        .last  (row_last_q),
        .cnt   (row_cnt),
        .wrap  (row_wrap)
    );

    mctrl_wrap_cnt #(.W(WColW)) u_wcol_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (row_wrap),
        .last  (wcol_last_q),
        .cnt   (wcol_cnt),
        .wrap  (wcol_wrap)
    );

    mctrl_wrap_cnt #(.W(AColW)) u_acol_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (wcol_wrap),
        .last  (acol_last_q),
        .cnt   (acol_cnt),
        .wrap  (acol_wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job configuration is captured only in the launch cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_last_q  <= '0;
            acol_last_q <= '0;
            wcol_last_q <= '0;
        end else if (launch) begin
            row_last_q  <= cfgRowLast;
            acol_last_q <= cfgAColLast;
            wcol_last_q <= cfgWColLast;
        end
    end

    // Drain cycle counter, held at zero outside DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 4'd1;
        end
    end

    // Next-state logic; abort takes priority over a simultaneous final step.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                    state_nxt = ST_IDLE;
                else if (accept && all_last)  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)                        state_nxt = ST_IDLE;
                else if (drain_cnt == DrainEnd)   state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from registered state and counters.
    always_comb begin
        busy      = (state == ST_RUN) || (state == ST_DRAIN);
        done      = (state == ST_DONE);
        stepValid = (state == ST_RUN);
        rowAPtr   = row_cnt;
        rowWPtr   = row_cnt;
        colAPtr   = acol_cnt;
        colWPtr   = wcol_cnt;
        accFirst  = stepValid && (row_cnt == '0);
        accLast   = stepValid && (row_cnt == row_last_q);
        dbgState  = state;
    end

    // The outer counter's wrap has no consumer; keep it visible for checkers.
    logic unused_acol_wrap;
    assign unused_acol_wrap = acol_wrap;

endmodule
